// File: rtl/wdg_cfg_seq_pkg.sv
// Shared types and constants for the watchdog configuration sequencer:
// command opcodes, sequencer states, register map offsets and unlock key.
package wdg_seq_pkg;

  typedef enum logic [1:0] {
    WR_CTRL = 2'd0,
    WR_PSCR = 2'd1,
    WR_CMP  = 2'd2,
    RD_STAT = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KEY_SETUP  = 3'd1,
    KEY_ACCESS = 3'd2,
    REG_SETUP  = 3'd3,
    REG_ACCESS = 3'd4,
    DONE       = 3'd5
  } state_t;

  // Byte offsets of the watchdog register file, relative to its base address.
  localparam logic [31:0] OFS_CTRL = 32'h0000_0000;
  localparam logic [31:0] OFS_PSCR = 32'h0000_0004;
  localparam logic [31:0] OFS_CNT  = 32'h0000_0008;
  localparam logic [31:0] OFS_CMP  = 32'h0000_000C;
  localparam logic [31:0] OFS_STAT = 32'h0000_0010;
  localparam logic [31:0] OFS_KEY  = 32'h0000_0014;

  // Unlock value; any other write to the watchdog re-locks it.
  localparam logic [31:0] KEY_VALUE = 32'h5F37_59DF;

  // Register offset targeted by a command opcode.
  function automatic logic [31:0] op_offset(input op_t op);
    logic [31:0] ofs;
    ofs = OFS_STAT;
    case (op)
      WR_CTRL: ofs = OFS_CTRL;
      WR_PSCR: ofs = OFS_PSCR;
      WR_CMP:  ofs = OFS_CMP;
      RD_STAT: ofs = OFS_STAT;
      default: ofs = OFS_STAT;
    endcase
    return ofs;
  endfunction

  // Opcodes that touch a register other than STAT need the key first.
  function automatic logic op_is_write(input op_t op);
    return (op != RD_STAT);
  endfunction

endpackage

// File: rtl/wdg_cfg_seq_if.sv
// Bundle of the command, response, watchdog-request and APB4 signals of the
// sequencer. "master" is the sequencer's view, "slave" the environment's.
interface wdg_cfg_seq_if;

  // Command channel: a command transfers on a cycle where valid and ready
  // are both 1; op and data must be held with valid until that cycle and
  // are don't-care afterwards. The response is a one-cycle rsp_valid pulse
  // with no back-pressure; rsp_data/rsp_err are meaningful only in it.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Watchdog reset-request level and its clear pulse.
  logic        irq;
  logic        irq_clr;

  // APB4 requester side.
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, irq, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, irq_clr,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, irq, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, irq_clr,
           paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/wdg_cfg_seq.sv
// Watchdog configuration sequencer: turns register commands into APB4
// transfers, prefixing every register write with the unlock KEY write, and
// services watchdog reset-requests by reading STAT on its own.
module wdg_cfg_seq
  import wdg_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned AUTO_CLR  = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // command / response
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  // watchdog reset-request
  input  logic        irq_i,
  output logic        irq_clr_o,
  // APB4 master
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  // debug view of the sequencer state
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  op_t         op_q;
  logic [31:0] data_q;
  logic        auto_q;      // current transaction is an automatic STAT read
  logic        err_q;
  logic [31:0] rdata_q;
  logic        svc_hold_q;  // first IDLE after a service: irq not yet cleared

  logic        svc_req;
  logic        accept_cmd;
  logic        accept_svc;
  logic        reg_wr;
  logic        access_done;

  // The request is looked at only in IDLE, and not in the IDLE cycle right
  // after a service DONE, since the watchdog drops irq one cycle after clear.
  assign svc_req     = (AUTO_CLR != 0) && irq_i && !svc_hold_q;
  assign reg_wr      = op_is_write(op_q) && !auto_q;
  assign access_done = ((state_q == KEY_ACCESS) || (state_q == REG_ACCESS)) && pready_i;
  assign dbg_state   = state_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, handshake, APB drive and response outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    accept_cmd  = 1'b0;
    accept_svc  = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    paddr_o     = 32'h0;
    pwrite_o    = 1'b0;
    pwdata_o    = 32'h0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = 32'h0;
    rsp_err_o   = 1'b0;
    irq_clr_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (svc_req) begin
          accept_svc = rst_n_i;
          state_d    = REG_SETUP;
        end else begin
          cmd_ready_o = rst_n_i;
          if (cmd_valid_i && rst_n_i) begin
            accept_cmd = 1'b1;
            state_d    = op_is_write(op_t'(cmd_op_i)) ? KEY_SETUP : REG_SETUP;
          end
        end
      end
      KEY_SETUP, KEY_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == KEY_ACCESS);
        paddr_o   = BASE_ADDR + OFS_KEY;
        pwrite_o  = 1'b1;
        pwdata_o  = KEY_VALUE;
        if (state_q == KEY_SETUP) state_d = KEY_ACCESS;
        else if (pready_i)        state_d = REG_SETUP;
      end
      REG_SETUP, REG_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == REG_ACCESS);
        paddr_o   = BASE_ADDR + op_offset(op_q);
        pwrite_o  = reg_wr;
        pwdata_o  = reg_wr ? data_q : 32'h0;
        if (state_q == REG_SETUP) state_d = REG_ACCESS;
        else if (pready_i)        state_d = DONE;
      end
      DONE: begin
        if (auto_q) begin
          irq_clr_o = 1'b1;
        end else begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = rdata_q;
          rsp_err_o   = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture at the transfer; later changes on cmd_* are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_q   <= RD_STAT;
      data_q <= 32'h0;
      auto_q <= 1'b0;
    end else if (accept_svc) begin
      op_q   <= RD_STAT;
      data_q <= 32'h0;
      auto_q <= 1'b1;
    end else if (accept_cmd) begin
      op_q   <= op_t'(cmd_op_i);
      data_q <= cmd_data_i;
      auto_q <= 1'b0;
    end
  end

  // Response capture: error is sticky across KEY and REG accesses, read
  // data is taken at the completing REG access of a read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (accept_svc || accept_cmd) begin
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (access_done) err_q <= err_q | pslverr_i;
      if (access_done && (state_q == REG_ACCESS) && !reg_wr) rdata_q <= prdata_i;
    end
  end

  // Service hold-off for the IDLE cycle that follows a service DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) svc_hold_q <= 1'b0;
    else          svc_hold_q <= (state_q == DONE) && auto_q;
  end

endmodule
